// File: rtl/lfsr_stream_if.sv
// Output word stream of lfsr_stream: valid/ready handshake plus data.
// The generator drives it through the master modport and the consumer through the slave modport.
interface lfsr_stream_if #(
    parameter int DW = 8
);
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;

    modport master (output out_valid, output out_data, input out_ready);
    modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/lfsr_stream.sv
// WIDTH-bit Fibonacci/Galois LFSR that produces one OUT_WIDTH word every STEPS shifts.
// It also supports entropy injection, runtime seeding and recovery from the all-zero state.
module lfsr_stream #(
    parameter int               WIDTH      = 16,
    parameter logic [WIDTH-1:0] INIT_VALUE = 16'hACE1,
    parameter logic [WIDTH-1:0] TAPS       = 16'h002D,
    parameter int               MODE       = 0,
    parameter int               INVERSE    = 0,
    parameter int               STEPS      = 1,
    parameter int               OUT_WIDTH  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             random,
    input  logic             seed_valid,
    input  logic [WIDTH-1:0] seed,
    lfsr_stream_if.master    out_if,
    output logic [WIDTH-1:0] state,
    output logic             lockup
);
    localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic {SHIFT, HOLD} fsm_t;

    fsm_t             fsm_q, fsm_d;
    logic [WIDTH-1:0] state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             lockup_q, lockup_d;
    // Cleared only by FPGA configuration, so the first edge loads reset values even without rst.
    logic             init_done_q = 1'b0;

    logic [WIDTH-1:0] shift_next;
    logic [WIDTH-1:0] shift_val;
    logic             locked;
    logic             xfer;
    logic             last_step;

    generate
        if (MODE == 1) begin : g_galois
            for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
                if (gi == WIDTH - 1) begin : g_top
                    assign shift_next[gi] = random ^ (state_q[0] & TAPS[gi]);
                end else begin : g_mid
                    assign shift_next[gi] = state_q[gi+1] ^ (state_q[0] & TAPS[gi]);
                end
            end
        end else if (INVERSE != 0) begin : g_fib_lsb
            assign shift_next = {state_q[WIDTH-2:0], random ^ (^(state_q & TAPS))};
        end else begin : g_fib_msb
            assign shift_next = {random ^ (^(state_q & TAPS)), state_q[WIDTH-1:1]};
        end
    endgenerate

    assign locked    = (state_q == '0);
    assign shift_val = locked ? INIT_VALUE : shift_next;
    assign xfer      = valid_q && out_if.out_ready;
    assign last_step = (cnt_q == CW'(STEPS - 1));

    always_ff @(posedge clk) begin
        if (rst || !init_done_q) begin
            fsm_q    <= SHIFT;
            state_q  <= INIT_VALUE;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            lockup_q <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            lockup_q <= lockup_d;
        end
        init_done_q <= 1'b1;
    end

    always_comb begin
        fsm_d = fsm_q;
        if (seed_valid) begin
            fsm_d = SHIFT;
        end else begin
            case (fsm_q)
                SHIFT:   if (last_step) fsm_d = HOLD;
                HOLD:    if (xfer && STEPS != 1) fsm_d = SHIFT;
                default: fsm_d = SHIFT;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        lockup_d = 1'b0;
        if (seed_valid) begin
            state_d  = (seed == '0) ? INIT_VALUE : seed;
            lockup_d = (seed == '0);
            cnt_d    = '0;
            valid_d  = 1'b0;
        end else if (fsm_q == SHIFT) begin
            state_d  = shift_val;
            lockup_d = locked;
            if (last_step) begin
                cnt_d   = '0;
                valid_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (xfer) begin
            // The accepting edge already performs the first shift of the next word.
            state_d  = shift_val;
            lockup_d = locked;
            if (STEPS == 1) begin
                cnt_d   = '0;
                valid_d = 1'b1;
            end else begin
                cnt_d   = CW'(1);
                valid_d = 1'b0;
            end
        end
    end

    assign out_if.out_valid = valid_q;
    assign out_if.out_data  = state_q[OUT_WIDTH-1:0];
    assign state            = state_q;
    assign lockup           = lockup_q;
endmodule

// File: tb/tb_lfsr_stream.sv
// Directed bench for lfsr_stream: four configurations share one clock.
// A queue-based monitor checks the delivered words, and the stimulus process checks state and timing directly.
module tb_lfsr_stream;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_f = 1'b0, rst_g = 1'b0, rst_i = 1'b0, rst_b = 1'b0;
    logic        rnd_g = 1'b0;
    logic        seed_valid_b = 1'b0;
    logic [15:0] seed_b = 16'h0;
    logic [15:0] st_f, st_g, st_i, st_b;
    logic        lk_f, lk_g, lk_i, lk_b;

    lfsr_stream_if #(.DW(8)) fib_if ();
    lfsr_stream_if #(.DW(8)) gal_if ();
    lfsr_stream_if #(.DW(8)) inv_if ();
    lfsr_stream_if #(.DW(8)) bp_if ();

    lfsr_stream #(.MODE(0), .INVERSE(0), .STEPS(1)) u_fib (
        .clk(clk), .rst(rst_f), .random(1'b0), .seed_valid(1'b0), .seed(16'h0),
        .out_if(fib_if), .state(st_f), .lockup(lk_f));
    lfsr_stream #(.MODE(1), .TAPS(16'hB400), .STEPS(1)) u_gal (
        .clk(clk), .rst(rst_g), .random(rnd_g), .seed_valid(1'b0), .seed(16'h0),
        .out_if(gal_if), .state(st_g), .lockup(lk_g));
    lfsr_stream #(.MODE(0), .INVERSE(1), .STEPS(1)) u_inv (
        .clk(clk), .rst(rst_i), .random(1'b0), .seed_valid(1'b0), .seed(16'h0),
        .out_if(inv_if), .state(st_i), .lockup(lk_i));
    lfsr_stream #(.MODE(0), .INVERSE(0), .STEPS(4)) u_bp (
        .clk(clk), .rst(rst_b), .random(1'b0), .seed_valid(seed_valid_b), .seed(seed_b),
        .out_if(bp_if), .state(st_b), .lockup(lk_b));

    int checks = 0;
    int errors = 0;
    logic [7:0] fib_q[$];
    logic [7:0] bp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_bp_valid(output int n);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            n++;
            if (bp_if.out_valid) break;
        end
    endtask

    // Monitor: the word on the bus when valid&ready is seen before an edge is the one transferred.
    initial begin : monitor
        logic [7:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (fib_if.out_valid && fib_if.out_ready && fib_q.size() > 0) begin
                e = fib_q.pop_front();
                check("fib_word", 32'(fib_if.out_data), 32'(e));
            end
            if (bp_if.out_valid && bp_if.out_ready && bp_q.size() > 0) begin
                e = bp_q.pop_front();
                check("bp_word", 32'(bp_if.out_data), 32'(e));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin : stim
        int n;
        fib_if.out_ready = 1'b1;
        gal_if.out_ready = 1'b1;
        inv_if.out_ready = 1'b1;
        bp_if.out_ready  = 1'b0;

        // The first edge loads reset values with rst low.
        tick();
        check("powerup_state", 32'(st_b), 32'h0000ACE1);
        check("powerup_valid", 32'(bp_if.out_valid), 32'h0);

        rst_f = 1'b1; rst_g = 1'b1; rst_i = 1'b1;
        tick();
        fib_q.push_back(8'h70);
        fib_q.push_back(8'h38);
        fib_q.push_back(8'h9C);
        check("fib_rst_state", 32'(st_f), 32'h0000ACE1);
        check("fib_rst_valid", 32'(fib_if.out_valid), 32'h0);
        rst_f = 1'b0; rst_g = 1'b0; rst_i = 1'b0;
        tick();
        check("fib_step1", 32'(st_f), 32'h00005670);
        check("fib_valid1", 32'(fib_if.out_valid), 32'h1);
        check("gal_step_r0", 32'(st_g), 32'h0000E270);
        check("inv_step", 32'(st_i), 32'h000059C2);
        tick();
        check("fib_step2", 32'(st_f), 32'h0000AB38);

        rst_g = 1'b1;
        tick();
        rst_g = 1'b0; rnd_g = 1'b1;
        tick();
        rnd_g = 1'b0;
        check("gal_step_r1", 32'(st_g), 32'h00006270);

        // Backpressure with STEPS=4.
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        wait_bp_valid(n);
        check("bp_latency", 32'(n), 32'd4);
        check("bp_word_state", 32'(st_b), 32'h00002ACE);
        repeat (10) tick();
        check("bp_frozen_state", 32'(st_b), 32'h00002ACE);
        check("bp_frozen_valid", 32'(bp_if.out_valid), 32'h1);
        bp_q.push_back(8'hCE);
        bp_if.out_ready = 1'b1;
        tick();
        bp_if.out_ready = 1'b0;
        check("bp_after_xfer_valid", 32'(bp_if.out_valid), 32'h0);
        check("bp_after_xfer_state", 32'(st_b), 32'h00001567);
        wait_bp_valid(n);
        check("bp_next_latency", 32'(n), 32'd3);
        check("bp_next_state", 32'(st_b), 32'h000022AC);

        // Seed while HOLD, with a transfer on the same edge.
        bp_q.push_back(8'hAC);
        bp_if.out_ready = 1'b1;
        seed_b = 16'h1234; seed_valid_b = 1'b1;
        tick();
        seed_valid_b = 1'b0; bp_if.out_ready = 1'b0;
        check("seed_state", 32'(st_b), 32'h00001234);
        check("seed_valid_low", 32'(bp_if.out_valid), 32'h0);
        wait_bp_valid(n);
        check("seed_latency", 32'(n), 32'd4);

        // Zero seed recovers to INIT_VALUE with a one-cycle lockup pulse.
        seed_b = 16'h0; seed_valid_b = 1'b1;
        tick();
        seed_valid_b = 1'b0;
        check("zseed_state", 32'(st_b), 32'h0000ACE1);
        check("zseed_lockup_hi", 32'(lk_b), 32'h1);
        tick();
        check("zseed_lockup_lo", 32'(lk_b), 32'h0);
        tick();
        check("midword_state", 32'(st_b), 32'h0000AB38);

        // Reset in the middle of a word.
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        check("midrst_state", 32'(st_b), 32'h0000ACE1);
        check("midrst_valid", 32'(bp_if.out_valid), 32'h0);
        wait_bp_valid(n);
        check("midrst_latency", 32'(n), 32'd4);

        for (int k = 0; k < 10; k++) begin
            if (fib_q.size() == 0 && bp_q.size() == 0) break;
            tick();
        end
        check("queues_drained", 32'(fib_q.size() + bp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lfsr_stream.md
# lfsr_stream

Parametrised pseudo-random word generator: a WIDTH-bit LFSR with Fibonacci or Galois feedback, optional entropy injection, runtime seed loading and all-zero lock-up recovery. It advances STEPS shifts per output word and delivers each word through a valid/ready handshake. It sits between entropy/noise sources and consumers such as scramblers, dither units and test-pattern generators.

## Interface

Parameters:
- WIDTH, 16: LFSR length in bits, ≥ 2.
- INIT_VALUE, 16'hACE1: power-up, reset and lock-up recovery state. Must be non-zero.
- TAPS, 16'h002D: feedback tap mask, WIDTH bits.
- MODE, 0: 0 = Fibonacci, 1 = Galois.
- INVERSE, 0: Fibonacci only. 0 = feedback enters at the MSB; 1 = feedback enters at the LSB. Ignored when MODE=1.
- STEPS, 1: shifts per output word, ≥ 1.
- OUT_WIDTH, 8: output word width, ≤ WIDTH.

Ports:
- clk, in, 1: clock. All logic is on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- random, in, 1: entropy bit XORed into the feedback. Sampled only on shift edges. Tie to 0 if unused.
- seed_valid, in, 1: load `seed` on this edge.
- seed, in, WIDTH: seed value.
- out_valid, out, 1: out_data holds a complete word.
- out_ready, in, 1: consumer accepts the word.
- out_data, out, OUT_WIDTH: state[OUT_WIDTH-1:0]. Driven combinationally from the state register.
- state, out, WIDTH: current LFSR register.
- lockup, out, 1: one-cycle pulse; high for the cycle after a recovery to INIT_VALUE.

## Operation

- FSM states are SHIFT and HOLD.
- Reset values: state=INIT_VALUE, step counter cnt=0, FSM=SHIFT, out_valid=0, lockup=0.
- Power-up: an internal init flag forces reset values on the first clock edge even if rst is low.
- Fibonacci shift:
  - fb = random ^ ^(state & TAPS).
  - INVERSE=0: next = {fb, state[WIDTH-1:1]}.
  - INVERSE=1: next = {state[WIDTH-2:0], fb}.
- Galois shift: next = {random, (WIDTH-1)'b0} ^ {1'b0, state[WIDTH-1:1]} ^ ({WIDTH{state[0]}} & TAPS).
- Lock-up recovery: on any shift edge where state == 0, load INIT_VALUE instead of next and pulse lockup. The edge still counts as a step.
- SHIFT state, each edge:
  - Perform one shift and increment cnt.
  - On the edge performing shift number STEPS: cnt<=0, out_valid<=1, FSM->HOLD.
- HOLD state: state and out_data are frozen while out_ready=0.
- Transfer occurs on any edge with out_valid && out_ready. That same edge performs the first shift of the next word (zero-bubble):
  - STEPS=1: out_valid stays 1 with the new word.
  - Otherwise: out_valid<=0, cnt<=1, FSM->SHIFT.
- Seed load (seed_valid=1):
  - Overrides shifting in any state: state<=seed, cnt<=0, out_valid<=0, FSM->SHIFT.
  - seed==0 loads INIT_VALUE and pulses lockup.
  - A transfer on the same edge still completes; the accepted word is the pre-load word.
- Priority: rst > power-up init > seed_valid > transfer/shift.
- rst mid-word or while HOLD discards the pending word. out_valid is 0 the cycle after.

## Timing

- Word latency: out_valid rises STEPS edges after the reset/seed edge.
- Throughput with out_ready held high: one word per STEPS cycles (one per cycle at STEPS=1).
- lockup is high exactly one cycle, following the recovery edge.
- out_data is guaranteed stable from out_valid rise until the transfer edge.

## Test plan

All scenarios use WIDTH=16, OUT_WIDTH=8 unless stated.

- Fibonacci step: MODE=0, INVERSE=0, STEPS=1, random=0, out_ready=1. Pulse rst, then release. Required: state sequence ACE1 -> 5670 -> AB38; out_data 70, then 38; out_valid high from the first post-reset edge.
- Galois step: MODE=1, TAPS=16'hB400, random=0. One shift from ACE1 -> E270. With random=1 instead: 6270.
- Backpressure: STEPS=4, out_ready=0. Required: out_valid rises on the 4th edge after reset and state stays frozen for 10 cycles. Raise out_ready for one cycle; required: exactly one transfer and out_valid=0 on the next cycle.
- Seed and lock-up:
  - seed_valid with seed=16'h1234 while in HOLD. Required: state=1234, out_valid=0, and out_valid re-rises STEPS edges later.
  - seed=0. Required: state=ACE1 and lockup pulses for exactly one cycle.
- INVERSE: MODE=0, INVERSE=1. One shift from ACE1 -> 59C2 (fb=0).
- Reset and power-up: assert rst in the middle of a STEPS=4 word. Required: state=ACE1, out_valid=0, cnt restarts. Without ever asserting rst, required: state=ACE1 after the first edge.
